alu_result_checker: RTL and testbench

- Self-checking monitor that sits on the output side of the combinational `alu`.
- Samples each issued operation (`opselect`, `x`, `y`) and the ALU's response (`res`, `v`, `c_out`, `zero`), and computes the golden result and flags.
- Compares the two, counts transactions and mismatches, and latches the first failing transaction for debug.
- Used in ALU benches and as an on-chip sanity monitor in the execute stage.

---
 rtl/alu_pkg.sv | 95 +++++++++
 rtl/alu_chk_delay.sv | 50 +++++
 rtl/alu_result_checker.sv | 142 ++++++++++++++
 tb/tb_alu_result_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, checker types and the golden ALU model used by alu_result_checker.
// Cover-index helpers serve the optional ALU_CHK_COVER_EN build.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam int COV_AND = 0;
    localparam int COV_OR  = 1;
    localparam int COV_ADD = 2;
    localparam int COV_SUB = 3;
    localparam int COV_SLT = 4;
    localparam int COV_NOR = 5;
    localparam int NUM_COV = 6;

    // flag_mask[1] enables the v compare, flag_mask[0] the c_out compare
    typedef struct packed {
        logic [31:0] res;
        logic        v;
        logic        c_out;
        logic        zero;
        logic [1:0]  flag_mask;
    } golden_t;

    typedef struct packed {
        logic [3:0] op;
        golden_t    gold;
    } chk_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FAILED
    } chk_state_t;

    function automatic logic op_checked(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_checked = 1'b1;
            default:                                       op_checked = 1'b0;
        endcase
    endfunction

    function automatic logic [NUM_COV-1:0] cov_onehot(input logic [3:0] op);
        cov_onehot = '0;
        case (op)
            OP_AND:  cov_onehot[COV_AND] = 1'b1;
            OP_OR:   cov_onehot[COV_OR]  = 1'b1;
            OP_ADD:  cov_onehot[COV_ADD] = 1'b1;
            OP_SUB:  cov_onehot[COV_SUB] = 1'b1;
            OP_SLT:  cov_onehot[COV_SLT] = 1'b1;
            OP_NOR:  cov_onehot[COV_NOR] = 1'b1;
            default: cov_onehot = '0;
        endcase
    endfunction

    function automatic golden_t alu_golden(input logic [3:0] op,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        golden_t     g;
        logic [32:0] sum;
        g           = '0;
        g.flag_mask = 2'b11;
        sum         = '0;
        case (op)
            OP_AND: g.res = x & y;
            OP_OR:  g.res = x | y;
            OP_ADD: begin
                sum     = {1'b0, x} + {1'b0, y};
                g.res   = sum[31:0];
                g.c_out = sum[32];
                g.v     = (x[31] == y[31]) && (sum[31] != x[31]);
            end
            OP_SUB: begin
                // c_out = 1 means no borrow
                sum     = {1'b0, x} + {1'b0, ~y} + 33'd1;
                g.res   = sum[31:0];
                g.c_out = sum[32];
                g.v     = (x[31] != y[31]) && (sum[31] != x[31]);
            end
            OP_SLT: begin
                g.res       = {31'b0, ($signed(x) < $signed(y))};
                g.flag_mask = 2'b00;
            end
            OP_NOR: g.res = ~(x | y);
            default: g.flag_mask = 2'b00;
        endcase
        g.zero = (g.res == 32'd0);
        return g;
    endfunction

endpackage

// File: rtl/alu_chk_delay.sv
// Valid+data shift register of DEPTH stages aligning golden values with a pipelined ALU.
// DEPTH = 0 is a pure pass-through; flush drops every in-flight entry.
module alu_chk_delay #(
    parameter int DEPTH = 0,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid & ~flush;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld;
            logic [W-1:0]     dat [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= '0;
                end else if (flush) begin
                    vld <= '0;
                end else begin
                    vld[0] <= in_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld[i] <= vld[i-1];
                    end
                end
            end

            // payload needs no reset: it is only observed behind its valid bit
            always_ff @(posedge clk) begin
                dat[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    dat[i] <= dat[i-1];
                end
            end

            assign out_valid = vld[DEPTH-1] & ~flush;
            assign out_data  = dat[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/alu_result_checker.sv
// Self-checking monitor comparing ALU outputs against a golden model, with counters and first-fail capture.
// Define ALU_CHK_COVER_EN to add the per-opcode cov_hit/cov_done coverage outputs.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int DUT_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       opselect,
    input  logic [31:0]      x,
    input  logic [31:0]      y,
    input  logic [31:0]      dut_res,
    input  logic             dut_v,
    input  logic             dut_c_out,
    input  logic             dut_zero,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_sticky,
    output logic [3:0]       fail_op,
    output logic [31:0]      fail_exp_res,
    output logic [31:0]      fail_got_res
`ifdef ALU_CHK_COVER_EN
    ,
    output logic [NUM_COV-1:0] cov_hit,
    output logic               cov_done
`endif
);

    chk_entry_t issue_entry;
    chk_entry_t al_entry;
    logic       issue_valid;
    logic       al_valid;
    logic       cmp_valid;
    logic       mismatch;
    chk_state_t state;
    chk_state_t state_next;

    assign issue_entry.op   = opselect;
    assign issue_entry.gold = alu_golden(opselect, x, y);
    assign issue_valid      = in_valid & op_checked(opselect);

    alu_chk_delay #(
        .DEPTH (DUT_LAT),
        .W     ($bits(chk_entry_t))
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clear),
        .in_valid  (issue_valid),
        .in_data   (issue_entry),
        .out_valid (al_valid),
        .out_data  (al_entry)
    );

    assign cmp_valid = al_valid & ~clear;
    assign mismatch  = (dut_res  != al_entry.gold.res)  ||
                       (dut_zero != al_entry.gold.zero) ||
                       (al_entry.gold.flag_mask[1] && (dut_v     != al_entry.gold.v)) ||
                       (al_entry.gold.flag_mask[0] && (dut_c_out != al_entry.gold.c_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else if (cmp_valid) begin
            case (state)
                ST_IDLE:   state_next = mismatch ? ST_FAILED : ST_RUN;
                ST_RUN:    state_next = mismatch ? ST_FAILED : ST_RUN;
                ST_FAILED: state_next = ST_FAILED;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    assign fail_sticky = (state == ST_FAILED);

    // counters saturate; capture only while not yet in FAILED so the first failure is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid    <= 1'b0;
            chk_pass     <= 1'b0;
            txn_count    <= '0;
            err_count    <= '0;
            fail_op      <= '0;
            fail_exp_res <= '0;
            fail_got_res <= '0;
        end else if (clear) begin
            chk_valid    <= 1'b0;
            chk_pass     <= 1'b0;
            txn_count    <= '0;
            err_count    <= '0;
            fail_op      <= '0;
            fail_exp_res <= '0;
            fail_got_res <= '0;
        end else begin
            chk_valid <= cmp_valid;
            if (cmp_valid) begin
                chk_pass <= ~mismatch;
                if (txn_count != '1) begin
                    txn_count <= txn_count + CNT_W'(1);
                end
                if (mismatch && (err_count != '1)) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (mismatch && (state != ST_FAILED)) begin
                    fail_op      <= al_entry.op;
                    fail_exp_res <= al_entry.gold.res;
                    fail_got_res <= dut_res;
                end
            end
        end
    end

`ifdef ALU_CHK_COVER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cov_hit <= '0;
        end else if (clear) begin
            cov_hit <= '0;
        end else if (cmp_valid && !mismatch) begin
            cov_hit <= cov_hit | cov_onehot(al_entry.op);
        end
    end

    assign cov_done = &cov_hit;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a DUT_LAT=0 instance and a DUT_LAT=2, CNT_W=3 instance.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  opselect = '0;
    logic [31:0] x = '0, y = '0, dut_res = '0;
    logic        dut_v = 1'b0, dut_c_out = 1'b0, dut_zero = 1'b0;
    logic        chk_valid, chk_pass, fail_sticky;
    logic [15:0] txn_count, err_count;
    logic [3:0]  fail_op;
    logic [31:0] fail_exp_res, fail_got_res;

    logic        l2_clear = 1'b0;
    logic        l2_in_valid = 1'b0;
    logic [3:0]  l2_opselect = '0;
    logic [31:0] l2_x = '0, l2_y = '0, l2_dut_res = '0;
    logic        l2_dut_v = 1'b0, l2_dut_c_out = 1'b0, l2_dut_zero = 1'b0;
    logic        l2_chk_valid, l2_chk_pass, l2_fail_sticky;
    logic [2:0]  l2_txn_count, l2_err_count;
    logic [3:0]  l2_fail_op;
    logic [31:0] l2_fail_exp_res, l2_fail_got_res;

`ifdef ALU_CHK_COVER_EN
    logic [5:0] cov_hit, l2_cov_hit;
    logic       cov_done, l2_cov_done;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.DUT_LAT(0), .CNT_W(16)) u_chk0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .opselect(opselect), .x(x), .y(y), .dut_res(dut_res), .dut_v(dut_v),
        .dut_c_out(dut_c_out), .dut_zero(dut_zero), .chk_valid(chk_valid),
        .chk_pass(chk_pass), .txn_count(txn_count), .err_count(err_count),
        .fail_sticky(fail_sticky), .fail_op(fail_op),
        .fail_exp_res(fail_exp_res), .fail_got_res(fail_got_res)
`ifdef ALU_CHK_COVER_EN
        , .cov_hit(cov_hit), .cov_done(cov_done)
`endif
    );

    alu_result_checker #(.DUT_LAT(2), .CNT_W(3)) u_chk2 (
        .clk(clk), .rst_n(rst_n), .clear(l2_clear), .in_valid(l2_in_valid),
        .opselect(l2_opselect), .x(l2_x), .y(l2_y), .dut_res(l2_dut_res), .dut_v(l2_dut_v),
        .dut_c_out(l2_dut_c_out), .dut_zero(l2_dut_zero), .chk_valid(l2_chk_valid),
        .chk_pass(l2_chk_pass), .txn_count(l2_txn_count), .err_count(l2_err_count),
        .fail_sticky(l2_fail_sticky), .fail_op(l2_fail_op),
        .fail_exp_res(l2_fail_exp_res), .fail_got_res(l2_fail_got_res)
`ifdef ALU_CHK_COVER_EN
        , .cov_hit(l2_cov_hit), .cov_done(l2_cov_done)
`endif
    );

    task automatic apply_stimulus(input logic v_in, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r, input logic fv,
                                  input logic fc, input logic fz);
        in_valid  = v_in;
        opselect  = op;
        x         = a;
        y         = b;
        dut_res   = r;
        dut_v     = fv;
        dut_c_out = fc;
        dut_zero  = fz;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (chk_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset chk_valid: got %b expected 0", chk_valid); end
        checks++; if (txn_count !== 16'd0) begin fails++; $display("[TB] FAIL reset txn_count: got %0d expected 0", txn_count); end
        checks++; if (err_count !== 16'd0) begin fails++; $display("[TB] FAIL reset err_count: got %0d expected 0", err_count); end
        checks++; if (fail_sticky !== 1'b0) begin fails++; $display("[TB] FAIL reset fail_sticky: got %b expected 0", fail_sticky); end
        checks++; if (l2_txn_count !== 3'd0) begin fails++; $display("[TB] FAIL reset l2_txn_count: got %0d expected 0", l2_txn_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_pass;
        @(negedge clk) apply_stimulus(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk) #1;
        checks++; if (chk_valid !== 1'b1) begin fails++; $display("[TB] FAIL add chk_valid: got %b expected 1", chk_valid); end
        checks++; if (chk_pass !== 1'b1) begin fails++; $display("[TB] FAIL add chk_pass: got %b expected 1", chk_pass); end
        checks++; if (txn_count !== 16'd1) begin fails++; $display("[TB] FAIL add txn_count: got %0d expected 1", txn_count); end
        checks++; if (err_count !== 16'd0) begin fails++; $display("[TB] FAIL add err_count: got %0d expected 0", err_count); end
        @(negedge clk) apply_stimulus(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
        @(posedge clk) #1;
        checks++; if (chk_pass !== 1'b1) begin fails++; $display("[TB] FAIL add_carry chk_pass: got %b expected 1", chk_pass); end
        checks++; if (txn_count !== 16'd2) begin fails++; $display("[TB] FAIL add_carry txn_count: got %0d expected 2", txn_count); end
    endtask

    task automatic test_sub_mismatch;
        @(negedge clk) apply_stimulus(1'b1, 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk) #1;
        checks++; if (chk_valid !== 1'b1) begin fails++; $display("[TB] FAIL sub chk_valid: got %b expected 1", chk_valid); end
        checks++; if (chk_pass !== 1'b0) begin fails++; $display("[TB] FAIL sub chk_pass: got %b expected 0", chk_pass); end
        checks++; if (err_count !== 16'd1) begin fails++; $display("[TB] FAIL sub err_count: got %0d expected 1", err_count); end
        checks++; if (fail_sticky !== 1'b1) begin fails++; $display("[TB] FAIL sub fail_sticky: got %b expected 1", fail_sticky); end
        checks++; if (fail_op !== 4'b0110) begin fails++; $display("[TB] FAIL sub fail_op: got %b expected 0110", fail_op); end
        checks++; if (fail_exp_res !== 32'd0) begin fails++; $display("[TB] FAIL sub fail_exp_res: got %h expected 0", fail_exp_res); end
        checks++; if (txn_count !== 16'd3) begin fails++; $display("[TB] FAIL sub txn_count: got %0d expected 3", txn_count); end
    endtask

    task automatic test_second_mismatch;
        @(negedge clk) apply_stimulus(1'b1, 4'b0001, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk) #1;
        checks++; if (chk_pass !== 1'b0) begin fails++; $display("[TB] FAIL or chk_pass: got %b expected 0", chk_pass); end
        checks++; if (err_count !== 16'd2) begin fails++; $display("[TB] FAIL or err_count: got %0d expected 2", err_count); end
        checks++; if (fail_op !== 4'b0110) begin fails++; $display("[TB] FAIL or fail_op: got %b expected 0110", fail_op); end
        checks++; if (fail_got_res !== 32'd0) begin fails++; $display("[TB] FAIL or fail_got_res: got %h expected 0", fail_got_res); end
    endtask

    task automatic test_other_ops;
        // SLT flags are masked, so deliberately wrong v/c_out must still pass
        @(negedge clk) apply_stimulus(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        @(posedge clk) #1;
        checks++; if (chk_pass !== 1'b1) begin fails++; $display("[TB] FAIL slt chk_pass: got %b expected 1", chk_pass); end
        @(negedge clk) apply_stimulus(1'b1, 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        @(posedge clk) #1;
        checks++; if (chk_pass !== 1'b1) begin fails++; $display("[TB] FAIL nor chk_pass: got %b expected 1", chk_pass); end
        @(negedge clk) apply_stimulus(1'b1, 4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1'b0);
        @(posedge clk) #1;
        checks++; if (chk_pass !== 1'b1) begin fails++; $display("[TB] FAIL and chk_pass: got %b expected 1", chk_pass); end
        checks++; if (txn_count !== 16'd7) begin fails++; $display("[TB] FAIL ops txn_count: got %0d expected 7", txn_count); end
        checks++; if (err_count !== 16'd2) begin fails++; $display("[TB] FAIL ops err_count: got %0d expected 2", err_count); end
    endtask

    task automatic test_unchecked;
        @(negedge clk) apply_stimulus(1'b1, 4'b1111, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk) #1;
        checks++; if (chk_valid !== 1'b0) begin fails++; $display("[TB] FAIL unchecked chk_valid: got %b expected 0", chk_valid); end
        checks++; if (txn_count !== 16'd7) begin fails++; $display("[TB] FAIL unchecked txn_count: got %0d expected 7", txn_count); end
        @(negedge clk) apply_stimulus(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_collision;
        @(negedge clk);
        apply_stimulus(1'b1, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        @(posedge clk) #1;
        checks++; if (chk_valid !== 1'b0) begin fails++; $display("[TB] FAIL clear chk_valid: got %b expected 0", chk_valid); end
        checks++; if (txn_count !== 16'd0) begin fails++; $display("[TB] FAIL clear txn_count: got %0d expected 0", txn_count); end
        checks++; if (err_count !== 16'd0) begin fails++; $display("[TB] FAIL clear err_count: got %0d expected 0", err_count); end
        checks++; if (fail_sticky !== 1'b0) begin fails++; $display("[TB] FAIL clear fail_sticky: got %b expected 0", fail_sticky); end
        checks++; if (fail_op !== 4'b0000) begin fails++; $display("[TB] FAIL clear fail_op: got %b expected 0000", fail_op); end
        @(negedge clk);
        clear = 1'b0;
        apply_stimulus(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset;
        @(negedge clk) apply_stimulus(1'b1, 4'b0000, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        @(posedge clk) #1;
        checks++; if (txn_count !== 16'd1) begin fails++; $display("[TB] FAIL pre_reset txn_count: got %0d expected 1", txn_count); end
        apply_stimulus(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (chk_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_reset chk_valid: got %b expected 0", chk_valid); end
        checks++; if (txn_count !== 16'd0) begin fails++; $display("[TB] FAIL async_reset txn_count: got %0d expected 0", txn_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic        exp_valid;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            l2_in_valid  = (k < 2);
            l2_opselect  = (k == 0) ? 4'b0010 : 4'b0000;
            l2_x         = (k == 0) ? 32'd1 : 32'd3;
            l2_y         = 32'd1;
            l2_dut_v     = 1'b0;
            l2_dut_c_out = 1'b0;
            l2_dut_zero  = 1'b0;
            l2_dut_res   = (k == 2) ? 32'd2 : (k == 3) ? 32'd1 : 32'hDEAD_BEEF;
            @(posedge clk) #1;
            exp_valid = (k == 2) || (k == 3);
            checks++; if (l2_chk_valid !== exp_valid) begin fails++; $display("[TB] FAIL b2b chk_valid k=%0d: got %b expected %b", k, l2_chk_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (l2_chk_pass !== 1'b1) begin fails++; $display("[TB] FAIL b2b chk_pass k=%0d: got %b expected 1", k, l2_chk_pass); end
            end
        end
        checks++; if (l2_txn_count !== 3'd2) begin fails++; $display("[TB] FAIL b2b txn_count: got %0d expected 2", l2_txn_count); end
        checks++; if (l2_err_count !== 3'd0) begin fails++; $display("[TB] FAIL b2b err_count: got %0d expected 0", l2_err_count); end
    endtask

    task automatic test_flush;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            l2_in_valid = (k == 0);
            l2_opselect = 4'b0010;
            l2_x        = 32'd1;
            l2_y        = 32'd1;
            l2_dut_res  = 32'd2;
            l2_dut_zero = 1'b0;
            l2_clear    = (k == 1);
            @(posedge clk) #1;
            if (k >= 1) begin
                checks++; if (l2_chk_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush chk_valid k=%0d: got %b expected 0", k, l2_chk_valid); end
            end
        end
        checks++; if (l2_txn_count !== 3'd0) begin fails++; $display("[TB] FAIL flush txn_count: got %0d expected 0", l2_txn_count); end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            l2_in_valid = (k < 9);
            l2_opselect = 4'b0000;
            l2_x        = 32'd0;
            l2_y        = 32'd0;
            l2_dut_res  = 32'd5;
            l2_dut_zero = 1'b0;
            @(posedge clk);
        end
        #1;
        checks++; if (l2_txn_count !== 3'd7) begin fails++; $display("[TB] FAIL sat txn_count: got %0d expected 7", l2_txn_count); end
        checks++; if (l2_err_count !== 3'd7) begin fails++; $display("[TB] FAIL sat err_count: got %0d expected 7", l2_err_count); end
        checks++; if (l2_fail_sticky !== 1'b1) begin fails++; $display("[TB] FAIL sat fail_sticky: got %b expected 1", l2_fail_sticky); end
        checks++; if (l2_fail_got_res !== 32'd5) begin fails++; $display("[TB] FAIL sat fail_got_res: got %h expected 5", l2_fail_got_res); end
    endtask

    initial begin
        $display("[TB] starting alu_result_checker bench");
        test_reset();
        test_add_pass();
        test_sub_mismatch();
        test_second_mismatch();
        test_other_ops();
        test_unchecked();
        test_clear_collision();
        test_async_reset();
        test_back_to_back();
        test_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
